// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C address-probe transmitter.
package i2c_pkg;

  localparam int         I2C_ADDR_W       = 7;
  localparam logic       I2C_ACK          = 1'b0;
  localparam int         QUARTERS_PER_BIT = 4;
  localparam logic [1:0] Q_LAST           = 2'(QUARTERS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } i2c_tx_state_t;

  // A slave acknowledges by holding SDA at the ACK level during the ninth clock.
  function automatic logic ack_seen(input logic sda_sample);
    return sda_sample == I2C_ACK;
  endfunction

endpackage

// File: rtl/i2c_addr_transmitter_if.sv
// Request/response and SDA/SCL pad signals between a caller and the address transmitter.
interface i2c_addr_transmitter_if;
  import i2c_pkg::*;

  logic                  start;
  logic [I2C_ADDR_W-1:0] I2C_addr;
  logic                  rw;
  logic                  sda_in;
  logic                  scl_out;
  logic                  sda_oe;
  logic                  busy;
  logic                  done;
  logic                  acked;

  modport master (
    input  start, I2C_addr, rw, sda_in,
    output scl_out, sda_oe, busy, done, acked
  );

  modport slave (
    output start, I2C_addr, rw, sda_in,
    input  scl_out, sda_oe, busy, done, acked
  );

endinterface

// File: rtl/i2c_addr_transmitter_checker.sv
// Protocol invariants of the transmitter's bus outputs.
module i2c_addr_transmitter_checker
  import i2c_pkg::*;
(
  input logic          clk_i,
  input logic          rst_i,
  input i2c_tx_state_t state_i,
  input logic          scl_i,
  input logic          sda_oe_i,
  input logic          done_i
);

  logic data_phase_s;
  assign data_phase_s = (state_i != START) && (state_i != STOP);

  a_sda_stable_scl_high: assert property (@(posedge clk_i) disable iff (rst_i)
    (scl_i && $past(scl_i) && data_phase_s && ($past(state_i) != START) && ($past(state_i) != STOP))
      |-> $stable(sda_oe_i));

  a_done_one_cycle: assert property (@(posedge clk_i) disable iff (rst_i)
    done_i |=> !done_i);

endmodule

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period timer: divides the system clock by CLK_DIV and tracks the quarter within a bit.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic       tick_o,
  output logic [1:0] qtr_o,
  output logic       first_o,
  output logic       pre_last_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt_q;
  logic [1:0]    qtr_q;

  assign tick_o     = en_i && (cnt_q == CNT_LAST);
  assign first_o    = en_i && (cnt_q == {CW{1'b0}});
  assign pre_last_o = en_i && (cnt_q == CNT_PRE);
  assign qtr_o      = qtr_q;

  // Counter held at zero while idle so a new transaction starts on a quarter boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CW{1'b0}};
      qtr_q <= 2'd0;
    end else if (!en_i) begin
      cnt_q <= {CW{1'b0}};
      qtr_q <= 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= {CW{1'b0}};
      qtr_q <= qtr_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_addr_transmitter.sv
// I2C master address probe: START, 7-bit address + R/W, ACK sample, STOP.
module i2c_addr_transmitter
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                   FPGA_clk,
  input  logic                   rst,
  i2c_addr_transmitter_if.master bus
);

  i2c_tx_state_t state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic [1:0]    sync_q;
  logic          scl_q;
  logic          sda_oe_q;
  logic          busy_q;
  logic          done_q;
  logic          acked_q;

  logic          tick_s;
  logic [1:0]    qtr_s;
  logic          first_s;
  logic          pre_last_s;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i      (FPGA_clk),
    .rst_i      (rst),
    .en_i       (busy_q),
    .tick_o     (tick_s),
    .qtr_o      (qtr_s),
    .first_o    (first_s),
    .pre_last_o (pre_last_s)
  );

  // Two-flop synchroniser for the asynchronous SDA pad.
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.sda_in};
    end
  end

  // Sequencer: on each quarter tick the outputs are loaded for the quarter that begins next.
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= 8'h00;
      bit_q    <= 3'd0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acked_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= START;
            busy_q   <= 1'b1;
            shift_q  <= {bus.I2C_addr, bus.rw};
            bit_q    <= 3'd7;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            if (qtr_s == Q_LAST) begin
              state_q  <= ADDR;
              scl_q    <= 1'b0;
              sda_oe_q <= ~shift_q[7];
            end else if (qtr_s == 2'd1) begin
              sda_oe_q <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (tick_s) begin
            if (qtr_s == 2'd1) begin
              scl_q <= 1'b1;
            end else if (qtr_s == Q_LAST) begin
              scl_q <= 1'b0;
              if (bit_q == 3'd0) begin
                state_q  <= ACK;
                sda_oe_q <= 1'b0;
              end else begin
                bit_q    <= bit_q - 3'd1;
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
        end
        ACK: begin
          if (first_s && (qtr_s == Q_LAST)) begin
            acked_q <= ack_seen(sync_q[1]);
          end
          if (tick_s) begin
            if (qtr_s == 2'd1) begin
              scl_q <= 1'b1;
            end else if (qtr_s == Q_LAST) begin
              state_q  <= STOP;
              scl_q    <= 1'b0;
              sda_oe_q <= 1'b1;
            end
          end
        end
        STOP: begin
          // done lands on the final cycle of the STOP slot, one cycle before busy drops.
          if (pre_last_s && (qtr_s == Q_LAST)) begin
            done_q <= 1'b1;
          end
          if (tick_s) begin
            if (qtr_s == 2'd1) begin
              scl_q <= 1'b1;
            end else if (qtr_s == 2'd2) begin
              sda_oe_q <= 1'b0;
            end else if (qtr_s == Q_LAST) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              scl_q    <= 1'b1;
              sda_oe_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          scl_q    <= 1'b1;
          sda_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scl_out = scl_q;
  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.acked   = acked_q;

  i2c_addr_transmitter_checker u_chk (
    .clk_i    (FPGA_clk),
    .rst_i    (rst),
    .state_i  (state_q),
    .scl_i    (scl_q),
    .sda_oe_i (sda_oe_q),
    .done_i   (done_q)
  );

endmodule

// File: tb/tb_i2c_addr_transmitter.sv
// Self-checking bench: open-drain bus with a modelled slave, compared against a quarter-level bus model.
module tb_i2c_addr_transmitter;

  localparam int CLK_DIV = 4;
  localparam int TXN_CYC = 44 * CLK_DIV;

  logic clk;
  logic rst;
  logic slave_ack_en;
  logic slave_pull;
  logic sda_line;
  logic slv_prev_scl;
  logic slv_prev_sda;
  logic slv_armed;
  int   slv_rises;
  logic prev_acked;
  int   checks;
  int   errors;

  i2c_addr_transmitter_if bus_if ();

  i2c_addr_transmitter #(.CLK_DIV(CLK_DIV)) dut (
    .FPGA_clk (clk),
    .rst      (rst),
    .bus      (bus_if)
  );

  assign sda_line      = ~(bus_if.sda_oe | slave_pull);
  assign bus_if.sda_in = sda_line;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: arms on START, counts 8 SCL rises, then holds SDA low for the ninth clock if acking.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_prev_scl <= 1'b1;
      slv_prev_sda <= 1'b1;
      slv_armed    <= 1'b0;
      slv_rises    <= 0;
      slave_pull   <= 1'b0;
    end else begin
      slv_prev_scl <= bus_if.scl_out;
      slv_prev_sda <= sda_line;
      if (slv_prev_scl && bus_if.scl_out && slv_prev_sda && !sda_line) begin
        slv_armed  <= 1'b1;
        slv_rises  <= 0;
        slave_pull <= 1'b0;
      end else if (slv_armed) begin
        if (!slv_prev_scl && bus_if.scl_out) slv_rises <= slv_rises + 1;
        if (slv_prev_scl && !bus_if.scl_out) begin
          if (slave_pull) begin
            slave_pull <= 1'b0;
            slv_armed  <= 1'b0;
          end else if (slv_rises == 8) begin
            slave_pull <= slave_ack_en;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected {scl, sda_oe} for quarter k of a transaction, from the slot rules.
  function automatic logic [1:0] model_bus(input logic [7:0] frame, input int k);
    int   slot;
    int   q;
    logic hi;
    slot = k / 4;
    q    = k % 4;
    hi   = (q >= 2);
    if (slot == 0)      return {1'b1, hi};
    else if (slot <= 8) return {hi, ~frame[8 - slot]};
    else if (slot == 9) return {hi, 1'b0};
    else                return {1'b1 & hi, (q != 3)};
  endfunction

  task automatic run_txn(input logic [6:0] a_addr, input logic a_rw, input logic a_ack,
                         input int intf_n, input logic [7:0] exp_bits);
    logic [7:0] frame;
    logic [7:0] got_bits;
    logic [3:0] exp_v;
    logic       p_scl;
    logic       p_sda;
    logic       stop_seen;
    int         k;
    frame     = {a_addr, a_rw};
    got_bits  = 8'h00;
    p_scl     = 1'b1;
    p_sda     = 1'b1;
    stop_seen = 1'b0;
    k         = 0;
    bus_if.start    = 1'b1;
    bus_if.I2C_addr = a_addr;
    bus_if.rw       = a_rw;
    slave_ack_en    = a_ack;
    @(posedge clk);
    for (int n = 1; n <= TXN_CYC + 1; n++) begin
      @(negedge clk);
      bus_if.start    = (n == intf_n);
      bus_if.I2C_addr = 7'($urandom);
      bus_if.rw       = 1'($urandom);
      if (n <= TXN_CYC) begin
        k     = (n - 1) / 4;
        exp_v = {1'b1, (n == TXN_CYC), model_bus(frame, k)};
      end else begin
        exp_v = 4'b0010;
      end
      chk($sformatf("wave@%0d", n),
          32'({bus_if.busy, bus_if.done, bus_if.scl_out, bus_if.sda_oe}), 32'(exp_v));
      if (n == 1)       chk("acked_hold", 32'(bus_if.acked), 32'(prev_acked));
      if (n == TXN_CYC) chk("acked", 32'(bus_if.acked), 32'(a_ack));
      if (!p_scl && bus_if.scl_out && (k >= 4) && (k <= 35)) got_bits = {got_bits[6:0], sda_line};
      if (p_scl && bus_if.scl_out && !p_sda && sda_line && (k == 43)) stop_seen = 1'b1;
      p_scl = bus_if.scl_out;
      p_sda = sda_line;
    end
    prev_acked = a_ack;
    chk("addr_bits", 32'(got_bits), 32'(exp_bits));
    chk("stop_seen", 32'(stop_seen), 32'(1'b1));
  endtask

  task automatic run_reset_mid(input logic [6:0] a_addr, input int at_n);
    bus_if.start    = 1'b1;
    bus_if.I2C_addr = a_addr;
    bus_if.rw       = 1'b0;
    slave_ack_en    = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= at_n; n++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
    end
    chk("busy_before_rst", 32'(bus_if.busy), 32'(1'b1));
    rst = 1'b1;
    #1;
    chk("rst_mid", 32'({bus_if.scl_out, bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.acked}),
        32'(5'b10000));
    repeat (3) @(negedge clk);
    rst        = 1'b0;
    prev_acked = 1'b0;
  endtask

  initial begin
    logic [6:0] r_addr;
    logic       r_rw;
    logic       r_ack;
    int         r_intf;
    checks          = 0;
    errors          = 0;
    prev_acked      = 1'b0;
    rst             = 1'b1;
    slave_ack_en    = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.I2C_addr = 7'h00;
    bus_if.rw       = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset", 32'({bus_if.scl_out, bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.acked}),
        32'(5'b10000));
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle", 32'({bus_if.scl_out, bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.acked}),
          32'(5'b10000));
    end

    run_txn(7'b0001000, 1'b0, 1'b1, 0, 8'b00010000);
    repeat (5) @(negedge clk);
    run_txn(7'b0010010, 1'b1, 1'b0, 0, 8'b00100101);
    repeat (5) @(negedge clk);
    run_txn(7'b0001000, 1'b0, 1'b1, 50, 8'b00010000);
    repeat (5) @(negedge clk);
    run_reset_mid(7'b1010101, 86);
    repeat (4) @(negedge clk);
    run_txn(7'b1100110, 1'b1, 1'b0, 0, 8'b11001101);
    run_txn(7'b0110011, 1'b0, 1'b1, 176, 8'b01100110);
    run_txn(7'b1111111, 1'b1, 1'b0, 0, 8'b11111111);

    for (int i = 0; i < 12; i++) begin
      r_addr = 7'($urandom);
      r_rw   = 1'($urandom);
      r_ack  = 1'($urandom);
      r_intf = int'($urandom_range(1, 176));
      if ($urandom_range(0, 1) == 0) repeat (int'($urandom_range(1, 8))) @(negedge clk);
      run_txn(r_addr, r_rw, r_ack, r_intf, {r_addr, r_rw});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
